// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small op-decoding helpers.
package muldiv_iter_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } mdState_t;

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the shared datapath: shift-add for multiply,
// restoring subtract/compare for divide.
module muldiv_step
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv,
    input  logic [2*WIDTH-1:0]   accIn,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   accOut,
    output logic                 qBit
);

    logic [WIDTH:0] mulSum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;
    logic           unusedDiffMsb;

    // Divide keeps {remainder, dividend/quotient} in the accumulator; the
    // quotient bit is returned separately and merged into bit 0 by the caller.
    always_comb begin
        mulSum  = {1'b0, accIn[2*WIDTH-1:WIDTH]} + {1'b0, (accIn[0] ? operand : '0)};
        shifted = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        fits    = (shifted >= {1'b0, operand});
        if (isDiv) begin
            accOut = {(fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), accIn[WIDTH-2:0], 1'b0};
            qBit   = fits;
        end else begin
            accOut = {mulSum, accIn[WIDTH-1:1]};
            qBit   = 1'b0;
        end
    end

    assign unusedDiffMsb = diff[WIDTH];

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply/divide unit with start/ready/annul
// handshake; returns {hi,lo} for the HI/LO path.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           op,
    input  logic                 start,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic                 busy,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdState_t             state, stateNext;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc, stepAcc, fixed;
    logic [WIDTH-1:0]     divisor, magA, magB, quot, rem;
    logic                 isDiv, negA, negB, stepQ;
    logic                 signA, signB, accept, divByZero;

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv   (isDiv),
        .accIn   (acc),
        .operand (divisor),
        .accOut  (stepAcc),
        .qBit    (stepQ)
    );

    // Most-negative maps to itself, which is the correct unsigned magnitude.
    always_comb begin
        signA     = isSignedOp(op) & opdata1_i[WIDTH-1];
        signB     = isSignedOp(op) & opdata2_i[WIDTH-1];
        magA      = signA ? -opdata1_i : opdata1_i;
        magB      = signB ? -opdata2_i : opdata2_i;
        accept    = start & ~annul;
        divByZero = isDivOp(op) & (opdata2_i == '0);
        quot      = (negA ^ negB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem       = negA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fixed     = isDiv ? {rem, quot} : ((negA ^ negB) ? -acc : acc);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b1;
        ready_o   = 1'b0;
        case (state)
            MD_IDLE: begin
                busy = 1'b0;
                if (accept) stateNext = divByZero ? MD_DONE : MD_CALC;
            end
            MD_CALC: begin
                if (annul)                              stateNext = MD_IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))      stateNext = MD_FIX;
            end
            MD_FIX:  stateNext = annul ? MD_IDLE : MD_DONE;
            MD_DONE: begin
                ready_o   = 1'b1;
                stateNext = MD_IDLE;
            end
            default: stateNext = MD_IDLE;
        endcase
    end

    // Operands are captured only on an accepted start, so a start while busy
    // cannot disturb an operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            divisor  <= '0;
            isDiv    <= 1'b0;
            negA     <= 1'b0;
            negB     <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        acc     <= {{WIDTH{1'b0}}, magA};
                        divisor <= magB;
                        isDiv   <= isDivOp(op);
                        negA    <= signA;
                        negB    <= signB;
                        if (divByZero) result_o <= {opdata1_i, {WIDTH{1'b1}}};
                    end
                end
                MD_CALC: begin
                    if (!annul) begin
                        acc <= {stepAcc[2*WIDTH-1:1], (isDiv ? stepQ : stepAcc[0])};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MD_FIX: begin
                    if (!annul) result_o <= fixed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: 32-bit and 8-bit instances, directed
// timing/annul/reset cases plus randomised operations against a reference model.
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [31:0] opA, opB;
    logic        start32, start8, annul;
    logic        busy32, ready32, busy8, ready8;
    logic [63:0] result32;
    logic [15:0] result8;

    logic [63:0] expQ32[$];
    logic [15:0] expQ8[$];
    logic [63:0] lastResult32;
    int          numVectors = 0;
    int          numMiscompares = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .op(op), .start(start32), .annul(annul),
        .opdata1_i(opA), .opdata2_i(opB),
        .busy(busy32), .ready_o(ready32), .result_o(result32)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .op(op), .start(start8), .annul(annul),
        .opdata1_i(opA[7:0]), .opdata2_i(opB[7:0]),
        .busy(busy8), .ready_o(ready8), .result_o(result8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model working in wide integers, independent of the datapath.
    function automatic logic [63:0] modelMd(input int w, input logic [1:0] mop,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, res;
        longint      sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        sa   = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        case (mop)
            MD_MULT:  res = 64'(sa * sb);
            MD_MULTU: res = ua * ub;
            default: begin
                if (ub == 64'd0) begin
                    res = (ua << w) | mask;
                end else begin
                    if (mop == MD_DIV) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'(ua / ub);
                        r = longint'(ua % ub);
                    end
                    res = ((64'(r) & mask) << w) | (64'(q) & mask);
                end
            end
        endcase
        if (w < 32) res = res & ((64'd1 << (2 * w)) - 64'd1);
        return res;
    endfunction

    always @(negedge clk) begin
        if (ready32) begin
            if (expQ32.size() == 0) checkOutput("spurious ready32", 64'd1, 64'd0);
            else                    checkOutput("result32", result32, expQ32.pop_front());
        end
        if (ready8) begin
            if (expQ8.size() == 0) checkOutput("spurious ready8", 64'd1, 64'd0);
            else                   checkOutput("result8", {48'b0, result8}, {48'b0, expQ8.pop_front()});
        end
    end

    // Drives start for one cycle; returns at the sampling point of cycle 1.
    task automatic applyStimulus(input bit sel8, input logic [1:0] mop, input logic [31:0] a,
                                 input logic [31:0] b, input bit push, input logic [63:0] expected);
        @(negedge clk);
        op  = mop;
        opA = a;
        opB = b;
        if (sel8) start8 = 1'b1;
        else      start32 = 1'b1;
        if (push) begin
            if (sel8) expQ8.push_back(expected[15:0]);
            else begin
                expQ32.push_back(expected);
                lastResult32 = expected;
            end
        end
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
        op      = 2'($urandom);
        opA     = $urandom;
        opB     = $urandom;
    endtask

    task automatic waitReady(input bit sel8, input int startC, input int expCycle);
        int c = startC;
        while (c < expCycle + 4 && !(sel8 ? ready8 : ready32)) begin
            @(negedge clk);
            c++;
        end
        if (sel8 ? ready8 : ready32)
            checkOutput(sel8 ? "ready8 cycle" : "ready32 cycle", 64'(c), 64'(expCycle));
        else
            checkOutput("ready timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]  mop;
        logic [31:0] a, b;
        rst = 1'b1; start32 = 1'b0; start8 = 1'b0; annul = 1'b0;
        op = 2'b00; opA = '0; opB = '0; lastResult32 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy32", {63'b0, busy32}, 64'd0);
        checkOutput("reset ready32", {63'b0, ready32}, 64'd0);
        checkOutput("reset result32", result32, 64'd0);
        checkOutput("reset result8", {48'b0, result8}, 64'd0);
        rst = 1'b0;

        // DIVU 100/7 with cycle-exact busy/ready profile
        applyStimulus(0, MD_DIVU, 32'd100, 32'd7, 1, {32'h2, 32'hE});
        for (int c = 1; c <= 35; c++) begin
            if (c <= 33) checkOutput("busy during op", {63'b0, busy32}, 64'd1);
            if (c == 35) checkOutput("busy after op", {63'b0, busy32}, 64'd0);
            checkOutput("ready pulse", {63'b0, ready32}, (c == 34) ? 64'd1 : 64'd0);
            @(negedge clk);
        end

        applyStimulus(0, MD_DIV, 32'hFFFFFFF9, 32'd2, 1, {32'hFFFFFFFF, 32'hFFFFFFFD});
        waitReady(0, 1, 34);
        applyStimulus(0, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1, {32'h0, 32'h80000000});
        waitReady(0, 1, 34);
        applyStimulus(0, MD_MULT, 32'hFFFFFFFF, 32'd2, 1, {32'hFFFFFFFF, 32'hFFFFFFFE});
        waitReady(0, 1, 34);
        applyStimulus(0, MD_MULTU, 32'hFFFFFFFF, 32'd2, 1, {32'h1, 32'hFFFFFFFE});
        waitReady(0, 1, 34);

        // Divide by zero short path
        applyStimulus(0, MD_DIVU, 32'd5, 32'd0, 1, {32'h5, 32'hFFFFFFFF});
        checkOutput("div0 busy c1", {63'b0, busy32}, 64'd1);
        waitReady(0, 1, 1);
        checkOutput("div0 busy c2", {63'b0, busy32}, 64'd0);

        // Annul mid-CALC
        applyStimulus(0, MD_DIVU, 32'd100, 32'd7, 0, 64'd0);
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        checkOutput("annul busy", {63'b0, busy32}, 64'd0);
        checkOutput("annul result held", result32, lastResult32);
        repeat (40) @(negedge clk);
        checkOutput("annul result still held", result32, lastResult32);

        // Start while busy is ignored
        applyStimulus(0, MD_MULTU, 32'h12345678, 32'h9ABCDEF0, 1, modelMd(32, MD_MULTU, 32'h12345678, 32'h9ABCDEF0));
        repeat (4) @(negedge clk);
        start32 = 1'b1; op = MD_DIVU; opA = 32'd1; opB = 32'd1;
        @(negedge clk);
        start32 = 1'b0;
        checkOutput("busy after ignored start", {63'b0, busy32}, 64'd1);
        waitReady(0, 6, 34);

        // Reset in the middle of a multiply
        applyStimulus(0, MD_MULT, 32'hFFFFFFFD, 32'd5, 0, 64'd0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset busy", {63'b0, busy32}, 64'd0);
        checkOutput("midreset result", result32, 64'd0);
        rst = 1'b0;
        lastResult32 = '0;

        // 8-bit instance
        applyStimulus(1, MD_DIV, 32'h81, 32'h03, 1, 64'hFFD6);
        waitReady(1, 1, 10);

        for (int i = 0; i < 10; i++) begin
            mop = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 4 == 1) ? 32'd0 : $urandom;
            if (i % 5 == 2) a = 32'h80000000;
            applyStimulus(0, mop, a, b, 1, modelMd(32, mop, a, b));
            waitReady(0, 1, (mop[1] && b == 32'd0) ? 1 : 34);
        end
        for (int i = 0; i < 10; i++) begin
            mop = 2'($urandom_range(0, 3));
            a = {24'b0, 8'($urandom)};
            b = (i % 4 == 3) ? 32'd0 : {24'b0, 8'($urandom)};
            if (i % 3 == 0) begin a = 32'h80; b = 32'hFF; end
            applyStimulus(1, mop, a, b, 1, modelMd(8, mop, a, b));
            waitReady(1, 1, (mop[1] && b == 32'd0) ? 1 : 10);
        end

        checkOutput("pending32", 64'(expQ32.size()), 64'd0);
        checkOutput("pending8", 64'(expQ8.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised iterative multiply/divide unit for the EX stage, successor to the fixed 32-bit divider.
- Covers signed/unsigned multiply and divide at any operand width.
- Uses one shared shift/add-subtract datapath with a start/ready/annul handshake.
- Returns a 2*WIDTH {hi,lo} result for the HI/LO path.
- Hazard logic stalls E on busy and forwards the result into the EX/MEM hi/lo registers on ready.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits; must be >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived localparam, not overridable.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
op  in  2  operation, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
start  in  1  launch request; accepted only in IDLE
annul  in  1  abort current operation (pipeline flush/exception)
opdata1_i  in  WIDTH  multiplicand / dividend
opdata2_i  in  WIDTH  multiplier / divisor
busy  out  1  high in any non-IDLE state; drives E-stage stall
ready_o  out  1  one-cycle pulse when result_o is valid
result_o  out  2*WIDTH  {hi,lo}. Multiply: hi = upper product, lo = lower product. Divide: hi = remainder, lo = quotient.

Behaviour:
Reset:
- rst=1 at any edge, including mid-operation: state=IDLE, busy=0, ready_o=0, result_o=0, counter=0, internal registers cleared.

FSM states: IDLE, CALC, FIX, DONE.
- IDLE & start & !annul:
  - Capture op and operands.
  - For signed ops, store absolute values and the result signs. Product sign = sign1^sign2. Quotient sign = sign1^sign2. Remainder sign = sign1.
  - Go to CALC with counter=0.
  - Exception: divide op with opdata2_i==0 goes directly to DONE.
- CALC: one iteration per cycle, counter increments, exits to FIX when counter==WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division; partial remainder is WIDTH+1 bits; the subtract/compare uses that full width.
- FIX: two's-complement negate the magnitude results per stored signs; register result_o; go to DONE.
- DONE: ready_o=1 for exactly this cycle; return to IDLE.
- Latency: start accepted in cycle 0 -> ready_o high in cycle WIDTH+2.
- Divide by zero: ready_o high in cycle 1; result_o = {hi=opdata1_i, lo=all ones}; busy high in cycle 1 only.

Holding and ignored inputs:
- result_o holds its value from DONE until the next FIX or divide-by-zero DONE, or reset.
- start while busy: ignored; captured operands must not change.
- op and operands are don't-care outside the start cycle.

Annul:
- annul=1 in CALC or FIX: next state IDLE, no ready_o pulse, result_o keeps its previous value.
- annul=1 in DONE: ready_o still pulses this cycle (result already committed), then IDLE.
- annul=1 together with start in IDLE: start ignored.

Arithmetic edge cases:
- Signed divide truncates toward zero; remainder takes the dividend's sign.
- DIV of most-negative by -1: quotient = most-negative (wraps), remainder = 0, no error flag.
- |most-negative| is handled as an unsigned WIDTH-bit magnitude; no extra bit is needed.

Decomposition:
- Shared package (alongside the existing control defines):
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU.
  - FSM state encodings MD_IDLE/MD_CALC/MD_FIX/MD_DONE.
- One sub-module: muldiv_step, a combinational single iteration that takes {mode, accumulator/partial remainder, operand} and returns the next accumulator/remainder and quotient bit. The FSM, counter and sign fix-up stay in the top.

Test Plan:
- DIVU, WIDTH=32, 100 / 7, start at cycle 0 -> ready_o pulse at cycle 34 only; result_o = {0x00000002, 0x0000000E}; busy high cycles 1-33.
- DIV -7 / 2 -> {hi=0xFFFFFFFF, lo=0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- MULT 0xFFFFFFFF * 2 -> {0xFFFFFFFF, 0xFFFFFFFE}. MULTU 0xFFFFFFFF * 2 -> {0x00000001, 0xFFFFFFFE}.
- DIVU 5 / 0 -> ready_o at cycle 1; result_o = {0x00000005, 0xFFFFFFFF}.
- Annul and ignored start:
  - DIVU 100/7, annul at cycle 10 -> busy=0 from cycle 11; no ready_o; result_o unchanged.
  - Second start at cycle 5 with different operands -> ignored; first result unaffected.
- rst at cycle 15 of a MULT -> cycle 16: busy=0, result_o=0. Then WIDTH=8 instance, DIV 0x81 / 0x03 -> {0xFF, 0xD6} at cycle 10.
